// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator: the CPU stores N, writes GO,
// polls STATUS and reads n! from RESULT, with one multiply per clock while busy.
module fact_accel (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  // 13! no longer fits in 32 bits
  localparam logic [3:0] MAX_N = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  n_q;
  logic [3:0]  cnt_q;
  logic [31:0] prod_q;
  logic [31:0] result_q;
  logic        done_q;
  logic        err_q;
  logic        busy;
  logic        start;
  logic        too_big;
  logic        last_step;

  assign start     = we && (a == ADDR_GO) && wd[0] && (state_q == IDLE);
  assign too_big   = (n_q > MAX_N);
  assign last_step = (cnt_q <= 4'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !too_big) state_d = BUSY;
      BUSY:    if (last_step)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == BUSY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q      <= 4'd0;
      cnt_q    <= 4'd0;
      prod_q   <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (we && (a == ADDR_N)) begin
        n_q <= wd[3:0];
      end
      if (start) begin
        cnt_q  <= n_q;
        prod_q <= 32'd1;
        done_q <= too_big;
        err_q  <= too_big;
        if (too_big) begin
          result_q <= 32'd0;
        end
      end else if (busy) begin
        if (!last_step) begin
          prod_q <= prod_q * {28'd0, cnt_q};
          cnt_q  <= cnt_q - 4'd1;
        end else begin
          result_q <= prod_q;
          done_q   <= 1'b1;
        end
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    rd = 32'd0;
    case (a)
      ADDR_N:      rd = {28'd0, n_q};
      ADDR_GO:     rd = 32'd0;
      ADDR_STATUS: rd = {29'd0, busy, err_q, done_q};
      ADDR_RESULT: rd = result_q;
      default:     rd = 32'd0;
    endcase
  end

endmodule

// File: doc/fact_accel.md
# fact_accel

Memory-mapped iterative factorial accelerator that sits on the MIPS SoC data bus beside the GPIO block. The SoC address decoder issues `we` and a 2-bit word select. The CPU writes an operand and a start command with `sw`, polls status with `lw`, and reads back n! computed one multiply per clock. It acts as the bus responder: the CPU initiates every access, and this block only latches writes and returns read data.

## Interface
- No parameters. Operand width is 4 bits and result width is 32 bits, both fixed.
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `we` in 1: write enable from the SoC address decoder, already qualified by address range.
- `a` in 2: word select, taken from byte address bits [3:2].
- `wd` in 32: write data, the CPU store data.
- `rd` out 32: read data, driven combinationally from `a` and the registers.

Register map (`a`):
- 0 `N`: R/W. Only bits [3:0] are stored; reads return zero-extended.
- 1 `GO`: W only. Writing with bit0=1 issues a start; reads return 0.
- 2 `STATUS`: R only. Bit0 = done, bit1 = err, bit2 = busy, other bits 0.
- 3 `RESULT`: R only. Holds the last completed n!.

## Operation
- State machine has two states:
  - IDLE (busy=0).
  - BUSY (busy=1).
- Start acceptance: a start is accepted when `we`=1, `a`=1, `wd[0]`=1 and state is IDLE. On that edge:
  - done and err are cleared.
  - `cnt` is loaded from `N`, or from the `wd[3:0]` being written to `N` on that same edge (not possible, since `a` selects one register; `N` is the stored value).
  - `prod` is set to 1.
  - For n ≤ 12, state goes to BUSY.
  - For n > 12 (13! overflows 32 bits), state stays IDLE, err←1, done←1, `RESULT`←0.
- BUSY step, on each edge:
  - If `cnt` > 1: `prod`←`prod`×`cnt` (32-bit product, truncation unreachable for n ≤ 12) and `cnt`←`cnt`−1.
  - Otherwise: `RESULT`←`prod`, done←1, state←IDLE.
- Ignored writes:
  - Start while BUSY: no effect on the state machine.
  - Writes to `a`=2 or `a`=3: no effect.
- Writing `N` while BUSY updates `N` only. The in-flight computation uses `cnt`, not `N`.
- done and err are sticky. Only an accepted start or reset clears them.
- `RESULT` is not updated during BUSY. Reads during BUSY return the previous result.
- `rd` is purely combinational from `a` and the registers. No read side effects.

## Timing
- Reset values:
  - State IDLE.
  - `N`=0, `cnt`=0, `prod`=0, `RESULT`=0.
  - done=0, err=0, busy=0.
  - `rd`=0 for every `a`.
- Reset asserted mid-computation returns all state to the reset values immediately (asynchronous). No result is produced.
- Latency is counted from the start-accept edge E:
  - done=1 and `RESULT` are valid after edge E+max(n,1).
  - busy=1 from E to E+max(n,1).
  - n=0: `RESULT`=1 at E+1.
  - n=1: `RESULT`=1 at E+1.
  - n=5: `RESULT`=120 at E+5.
  - n=12: `RESULT`=479001600 at E+12.
- Error path: err and done are set at edge E. busy never asserts.
- `STATUS` sampled in the same cycle as the completing edge's result shows the new value one cycle later. A CPU `lw` polling loop sees done at the first read after completion.
- Back-to-back start: a start written in the cycle after done rises is accepted normally.

## Test plan
- Reset check: drive `rst`=0 mid-idle. Then `rd` for `a`=0..3 must be 0.
- Single computation:
  - Stimulus: write `N`=5, then `GO`=1.
  - Response: busy=1 for 5 cycles, then `STATUS`=0x1 and `RESULT`=120.
  - Reading `RESULT` at cycle E+3 returns 0 (the prior value).
- Edge operands:
  - n=0 → `RESULT`=1 at E+1.
  - n=1 → `RESULT`=1 at E+1.
  - n=12 → `RESULT`=0x1C8CFC00 at E+12.
- Overflow guard:
  - Stimulus: `N`=13, then `GO`.
  - Response: `STATUS`=0x3 at E, `RESULT`=0, busy never 1.
  - A following `N`=3 and `GO` must clear err, giving `STATUS`=0x1 and `RESULT`=6.
- Busy interference:
  - Stimulus: start with n=6. At E+2 write `N`=2 and `GO`=1.
  - Response: `RESULT`=720 at E+6, and `N` reads back 2.
- Reset mid-operation:
  - Stimulus: start with n=10, then assert `rst` at E+4.
  - Response: all registers return to 0, busy=0, done=0.
  - A restart with n=4 yields 24.
